// File: rtl/add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_pkg
// Purpose  : Shared types and constants for the add sequencer slice.
//            data_t  - operand/result word
//            cmd_t   - queued command {op_type, arg1, arg2}
//            rsp_t   - captured result {res, ov}
//            OP_ADD / OP_SUB - op_type encodings understood by `add`
// Revision : 1.0 - initial release
// ============================================================================
package add_pkg;

    // Width of the `add` datapath. The add_seq DATA_WIDTH parameter must match.
    localparam int unsigned ADD_DATA_WIDTH = 32;

    typedef logic [ADD_DATA_WIDTH-1:0] data_t;

    typedef struct packed {
        logic  op_type;
        data_t arg1;
        data_t arg2;
    } cmd_t;

    typedef struct packed {
        data_t res;
        logic  ov;
    } rsp_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO.
// Ports    : clk, reset_n (async, active-high)
//            i_push / i_push_data  - write side (ignored when full)
//            i_pop                 - read side (ignored when empty)
//            o_head                - current head word, zero while empty
//            o_full / o_empty / o_count - occupancy status
// Notes    : DEPTH must be a power of two. Pointers carry one extra wrap bit;
//            full/empty compare the wrap bit against the index bits.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned IW = (AW > 0) ? AW : 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IW-1:0]    w_wr_idx;
    logic [IW-1:0]    w_rd_idx;
    logic             w_push_en;
    logic             w_pop_en;

    generate
        if (AW > 0) begin : g_multi
            assign w_wr_idx = r_wr_ptr[AW-1:0];
            assign w_rd_idx = r_rd_ptr[AW-1:0];
            assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        end else begin : g_single
            // One entry: the pointer is only the wrap bit.
            assign w_wr_idx = '0;
            assign w_rd_idx = '0;
            assign o_full   = (r_wr_ptr != r_rd_ptr);
        end
    endgenerate

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign w_push_en = i_push & ~o_full;
    assign w_pop_en  = i_pop & ~o_empty;

    // Gating keeps the head at zero while empty, so stale storage never leaks.
    assign o_head = o_empty ? '0 : r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/add_seq.sv
`default_nettype none
// ============================================================================
// Module   : add_seq
// Purpose  : Operand sequencer and result collector around the `add` unit.
//            Commands are queued, issued one per cycle to `add` while result
//            credits remain, and the result is captured ADD_LATENCY edges
//            later into a result FIFO with a valid/ready output.
// Ports    : clk, reset_n (async, active-high)
//            in_valid/in_ready/in_op_type/in_arg1/in_arg2 - command input
//            op_type/arg1/arg2  - registered operands to `add`
//            res/ov             - result from `add`
//            out_valid/out_ready/out_res/out_ov - result output
// Options  : ADD_SEQ_STATS_EN adds issue_cnt[31:0] and ov_cnt[31:0].
// Revision : 1.0 - initial release
// ============================================================================
module add_seq
    import add_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = ADD_DATA_WIDTH,
    parameter int unsigned ADD_LATENCY = 2,
    parameter int unsigned CMD_DEPTH   = 4,
    parameter int unsigned RES_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_op_type,
    input  logic [DATA_WIDTH-1:0] in_arg1,
    input  logic [DATA_WIDTH-1:0] in_arg2,
    output logic                  op_type,
    output logic [DATA_WIDTH-1:0] arg1,
    output logic [DATA_WIDTH-1:0] arg2,
    input  logic [DATA_WIDTH-1:0] res,
    input  logic                  ov,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_res,
    output logic                  out_ov
`ifdef ADD_SEQ_STATS_EN
    ,
    output logic [31:0]           issue_cnt,
    output logic [31:0]           ov_cnt
`endif
);

    localparam int unsigned CW = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned RW = $clog2(RES_DEPTH) + 1;

    cmd_t                   w_cmd_push;
    cmd_t                   w_cmd_head;
    rsp_t                   w_rsp_push;
    rsp_t                   w_rsp_head;
    logic                   w_cmd_full;
    logic                   w_cmd_empty;
    logic [CW-1:0]          w_cmd_count_unused;
    logic                   w_res_full_unused;
    logic                   w_res_empty;
    logic [RW-1:0]          w_res_count;
    logic                   r_ready_en;
    logic [ADD_LATENCY-1:0] r_tag;
    logic [31:0]            w_inflight;
    logic [31:0]            w_credit_used;
    logic                   w_push;
    logic                   w_issue;
    logic                   w_capture;
    logic                   w_pop;

    // ------------------------------------------------------------------
    // Command side
    // ------------------------------------------------------------------
    // r_ready_en holds in_ready low through reset and releases it on the
    // first edge afterwards; the FIFO pointers alone would show "not full".
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) r_ready_en <= 1'b0;
        else         r_ready_en <= 1'b1;
    end

    assign in_ready = r_ready_en & ~w_cmd_full;
    assign w_push   = in_valid & in_ready;

    assign w_cmd_push.op_type = in_op_type;
    assign w_cmd_push.arg1    = in_arg1;
    assign w_cmd_push.arg2    = in_arg2;

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data (w_cmd_push),
        .i_pop       (w_issue),
        .o_head      (w_cmd_head),
        .o_full      (w_cmd_full),
        .o_empty     (w_cmd_empty),
        .o_count     (w_cmd_count_unused)
    );

    // ------------------------------------------------------------------
    // Issue with credit check: every command in flight or already parked in
    // the result FIFO holds one result slot, so the capture never overflows.
    // ------------------------------------------------------------------
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ADD_LATENCY; i++) begin
            w_inflight = w_inflight + 32'(r_tag[i]);
        end
    end

    assign w_credit_used = w_inflight + 32'(w_res_count);
    assign w_issue       = ~w_cmd_empty & (w_credit_used < RES_DEPTH);

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            op_type <= 1'b0;
            arg1    <= '0;
            arg2    <= '0;
        end else if (w_issue) begin
            op_type <= w_cmd_head.op_type;
            arg1    <= w_cmd_head.arg1;
            arg2    <= w_cmd_head.arg2;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: a set bit marks an issued command whose result is due.
    // ------------------------------------------------------------------
    generate
        if (ADD_LATENCY == 1) begin : g_tag_one
            always_ff @(posedge clk or posedge reset_n) begin
                if (reset_n) r_tag <= '0;
                else         r_tag <= w_issue;
            end
        end else begin : g_tag_shift
            always_ff @(posedge clk or posedge reset_n) begin
                if (reset_n) r_tag <= '0;
                else         r_tag <= {r_tag[ADD_LATENCY-2:0], w_issue};
            end
        end
    endgenerate

    assign w_capture = r_tag[ADD_LATENCY-1];

    // ------------------------------------------------------------------
    // Result side
    // ------------------------------------------------------------------
    assign w_rsp_push.res = res;
    assign w_rsp_push.ov  = ov;
    assign out_valid      = ~w_res_empty;
    assign w_pop          = out_valid & out_ready;
    assign out_res        = w_rsp_head.res;
    assign out_ov         = w_rsp_head.ov;

    sync_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_capture),
        .i_push_data (w_rsp_push),
        .i_pop       (w_pop),
        .o_head      (w_rsp_head),
        .o_full      (w_res_full_unused),
        .o_empty     (w_res_empty),
        .o_count     (w_res_count)
    );

`ifdef ADD_SEQ_STATS_EN
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            issue_cnt <= '0;
            ov_cnt    <= '0;
        end else begin
            if (w_issue)          issue_cnt <= issue_cnt + 32'd1;
            if (w_capture && ov)  ov_cnt    <= ov_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/add_seq.md
Name: add_seq

Overview:
- Operand sequencer that sits directly upstream of the `add` datapath unit and also collects its results.
- Accepts add/sub commands on a valid/ready interface and buffers them in a command FIFO.
- Issues at most one command per cycle to `add` and tracks the fixed `add` latency with a tag pipeline.
- Captures `res`/`ov` into a result FIFO presented on a valid/ready output, giving `add` (which has no handshake) flow control and in-order throughput.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match `add`.
- ADD_LATENCY, 2, clk edges from an operand-register update until `res`/`ov` reflect it; must be ≥1.
- CMD_DEPTH, 4, command FIFO entries; must be a power of 2.
- RES_DEPTH, 4, result FIFO entries; must be a power of 2 and ≥1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-high.
- in_valid  in  1  command valid.
- in_ready  out  1  command FIFO not full.
- in_op_type  in  1  1 = add, 0 = sub.
- in_arg1  in  DATA_WIDTH  first operand.
- in_arg2  in  DATA_WIDTH  second operand.
- op_type  out  1  to `add`; registered.
- arg1  out  DATA_WIDTH  to `add`; registered.
- arg2  out  DATA_WIDTH  to `add`; registered.
- res  in  DATA_WIDTH  from `add`.
- ov  in  1  from `add`.
- out_valid  out  1  result FIFO not empty.
- out_ready  in  1  consumer accepts the result.
- out_res  out  DATA_WIDTH  result at the FIFO head.
- out_ov  out  1  overflow flag at the FIFO head.

Behaviour:

Reset:
- reset_n=1 asynchronously clears both FIFOs, the tag pipeline and the credit count.
- During reset: op_type/arg1/arg2=0, in_ready=0, out_valid=0, out_res=0, out_ov=0.
- Reset mid-operation discards all in-flight and buffered results; none appear after release.
- in_ready rises the first cycle after release.

Command push:
- A command is pushed on a clk edge when in_valid & in_ready.
- in_ready = !cmd_full. It does not depend on a same-cycle pop, so a full FIFO never accepts, even while popping.

Issue:
- Issue condition: cmd_not_empty & (inflight + res_count < RES_DEPTH).
- On issue, at that edge:
  - the FIFO head is popped;
  - op_type/arg1/arg2 are loaded from the head;
  - tag[0] is set to 1.
- With no issue, operand outputs hold their last value and tag[0] is set to 0.

Tag pipeline and capture:
- tag is an ADD_LATENCY-stage shift register.
- Capture occurs at the edge where tag[ADD_LATENCY-1]=1, i.e. ADD_LATENCY edges after issue. At that edge `res`/`ov` are pushed into the result FIFO.
- The credit check guarantees the result FIFO never overflows. A capture is never dropped and is independent of out_ready.

Counting:
- inflight = number of set tag bits.
- A same-cycle capture and pop leaves res_count unchanged.

Output and throughput:
- A result pops at an edge when out_valid & out_ready.
- out_res/out_ov are the FIFO head, combinational from storage; they are stable while out_valid=1 and out_ready=0.
- Ordering: results leave in command order.
- Throughput: 1 command/cycle sustained when out_ready=1 and RES_DEPTH ≥ ADD_LATENCY+1.
- Minimum latency: 1 (FIFO write) + 1 (issue) + ADD_LATENCY (capture) edges from in handshake to out_valid. Default: 4 cycles.
- Pointers are log2(depth)+1 bits and wrap naturally; full/empty are decided by comparing the MSB and the remaining bits.
- No arithmetic is performed here; `res`/`ov` are passed through unmodified.

Optional Feature:
- Macro: ADD_SEQ_STATS_EN.
- When defined, two extra output ports are added:
  - issue_cnt[31:0]: increments on each issue.
  - ov_cnt[31:0]: increments on each capture with ov=1.
- Both counters wrap 0xFFFFFFFF→0 and are cleared by reset_n.
- When not defined, the ports and logic are absent, and the remaining behaviour is identical.

Decomposition:
- Package `add_pkg`:
  - data_t (logic[DATA_WIDTH-1:0]);
  - cmd_t packed struct {op_type, arg1, arg2};
  - rsp_t packed struct {res, ov};
  - constants OP_ADD=1'b1, OP_SUB=1'b0.
- Sub-module `sync_fifo`, parameterised on width and depth, with push/pop/full/empty/count and a first-word head output. It is instantiated twice: cmd_t × CMD_DEPTH and rsp_t × RES_DEPTH.
- Issue logic, tag pipeline and credit logic live in add_seq itself.

Test Plan:
1. Push {1,120,12}, out_ready=1 → after 4 cycles out_valid=1, out_res=132, out_ov=0.
2. Push {0,120,12} → out_res=108, out_ov=0.
3. Push {1,32'hFFFFFFFF,1} → out_res=0, out_ov=1. With ADD_SEQ_STATS_EN, ov_cnt=1.
4. out_ready=0, stream 10 commands {1,i,i} for i=0..9 →
   - exactly 4 issues;
   - in_ready falls once 4 are queued in the command FIFO;
   - out_res holds 0 while out_ready=0;
   - after out_ready=1, results 0,2,4,…,18 emerge in order with none lost.
5. Back-to-back 16 commands with out_ready=1 → out_valid high 16 consecutive cycles after the 4-cycle latency.
6. Assert reset_n=1 asynchronously with 2 commands in flight and 3 queued → all outputs 0 immediately; after release, out_valid stays 0 until new commands are pushed.
